// File: rtl/priority_arbiter_pkg.sv
// Shared encodings for the priority arbiter: FSM states and arbitration modes.
package priority_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational lowest-set-bit finder: returns the lowest set index of vec and
// whether any bit was set at all.
module prio_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    idx   = {IW{1'b0}};
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = vec[i] ? IW'(i) : idx;
      found = found | vec[i];
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Fixed-priority / round-robin arbiter with a valid/ready grant handshake.
// Grants are held stable until accepted; outputs come straight from registers.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_t         state_r;
  state_t         next_state_s;
  logic [W-1:0]   ptr_r;
  logic [W-1:0]   ptr_inc_s;
  logic [W-1:0]   ptr_eff_s;
  logic           handshake_s;
  logic           eligible_s;
  logic [N-1:0]   mask_s;
  logic [N-1:0]   masked_req_s;
  logic [N-1:0]   rev_req_s;
  logic [W-1:0]   hi_idx_s;
  logic [W-1:0]   lo_idx_s;
  logic [W-1:0]   rev_idx_s;
  logic           hi_found_s;
  logic           lo_found_s;
  logic           rev_found_s;
  logic [W-1:0]   winner_s;
  logic           nxt_valid_s;
  logic [W-1:0]   nxt_idx_s;
  logic [N-1:0]   nxt_onehot_s;

  assign handshake_s = grant_valid & grant_ready;

  // On a handshake the search starts just past the accepted channel.
  always_comb begin
    if (grant_idx == LAST_IDX) begin
      ptr_inc_s = {W{1'b0}};
    end else begin
      ptr_inc_s = grant_idx + W'(1);
    end
    ptr_eff_s = handshake_s ? ptr_inc_s : ptr_r;
    for (int i = 0; i < N; i++) begin
      mask_s[i]    = (i >= int'(ptr_eff_s));
      rev_req_s[i] = req[N-1-i];
    end
    masked_req_s = req & mask_s;
  end

  prio_pick #(.N(N)) u_pick_masked (
    .vec   (masked_req_s),
    .idx   (hi_idx_s),
    .found (hi_found_s)
  );

  prio_pick #(.N(N)) u_pick_all (
    .vec   (req),
    .idx   (lo_idx_s),
    .found (lo_found_s)
  );

  // Fixed priority wants the highest index: lowest set bit of the reversed vector.
  prio_pick #(.N(N)) u_pick_fixed (
    .vec   (rev_req_s),
    .idx   (rev_idx_s),
    .found (rev_found_s)
  );

  // Winner selection and next-state / next-output logic.
  always_comb begin
    if (mode == MODE_RR) begin
      winner_s   = hi_found_s ? hi_idx_s : lo_idx_s;
      eligible_s = enable & lo_found_s;
    end else begin
      winner_s   = LAST_IDX - rev_idx_s;
      eligible_s = enable & rev_found_s;
    end

    next_state_s = state_r;
    nxt_valid_s  = grant_valid;
    nxt_idx_s    = grant_idx;
    nxt_onehot_s = grant_onehot;

    case (state_r)
      IDLE: begin
        if (eligible_s) begin
          next_state_s = HOLD;
          nxt_valid_s  = 1'b1;
          nxt_idx_s    = winner_s;
          nxt_onehot_s = ONE_N << winner_s;
        end else begin
          next_state_s = IDLE;
          nxt_valid_s  = 1'b0;
          nxt_idx_s    = {W{1'b0}};
          nxt_onehot_s = {N{1'b0}};
        end
      end
      HOLD: begin
        if (handshake_s && eligible_s) begin
          next_state_s = HOLD;
          nxt_valid_s  = 1'b1;
          nxt_idx_s    = winner_s;
          nxt_onehot_s = ONE_N << winner_s;
        end else if (handshake_s) begin
          next_state_s = IDLE;
          nxt_valid_s  = 1'b0;
          nxt_idx_s    = {W{1'b0}};
          nxt_onehot_s = {N{1'b0}};
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
        nxt_valid_s  = 1'b0;
        nxt_idx_s    = {W{1'b0}};
        nxt_onehot_s = {N{1'b0}};
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= {W{1'b0}};
      grant_valid  <= 1'b0;
      grant_idx    <= {W{1'b0}};
      grant_onehot <= {N{1'b0}};
    end else begin
      state_r      <= next_state_s;
      grant_valid  <= nxt_valid_s;
      grant_idx    <= nxt_idx_s;
      grant_onehot <= nxt_onehot_s;
      if (handshake_s) begin
        ptr_r <= ptr_inc_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter (N=16): directed table, corner
// sequences, and a randomized run against a circular-scan reference model.
module tb_priority_arbiter;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         mode;
  logic [N-1:0] req;
  logic         grant_ready;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;

  int checks   = 0;
  int failures = 0;

  priority_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .req          (req),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        en;
    logic [15:0] req;
    logic        exp_valid;
    int          exp_idx;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_grant(input string name, input logic exp_valid, input int exp_idx);
    logic [N-1:0] one;
    logic [N-1:0] exp_oh;
    one    = 16'h0001;
    exp_oh = exp_valid ? (one << exp_idx) : 16'h0000;
    chk({name, ".valid"}, 64'(grant_valid), 64'(exp_valid));
    chk({name, ".idx"}, 64'(grant_idx), exp_valid ? 64'(exp_idx) : 64'd0);
    chk({name, ".onehot"}, 64'(grant_onehot), 64'(exp_oh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference: fixed priority is the highest set index.
  function automatic int fixed_pick(input logic [N-1:0] r);
    for (int j = N - 1; j >= 0; j--) if (r[j]) return j;
    return -1;
  endfunction

  // Reference: round-robin scans circularly starting at p.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    int m_valid;
    int m_idx;
    int m_ptr;
    int w;
    int wait_cnt[N];
    int max_wait;
    bit hs;

    rst = 1'b1; enable = 1'b0; mode = 1'b0; req = 16'h0000; grant_ready = 1'b0;
    #3;
    chk_grant("reset_async", 1'b0, 0);
    tick();
    rst = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 16'h0112, 1'b1, 8};
    tbl[1] = '{1'b0, 1'b1, 16'h0001, 1'b1, 0};
    tbl[2] = '{1'b0, 1'b1, 16'h8000, 1'b1, 15};
    tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 15};
    tbl[4] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 0};
    tbl[5] = '{1'b1, 1'b1, 16'h0110, 1'b1, 4};
    tbl[6] = '{1'b1, 1'b1, 16'h8000, 1'b1, 15};
    tbl[7] = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 0};
    tbl[8] = '{1'b1, 1'b1, 16'h0000, 1'b0, 0};
    tbl[9] = '{1'b0, 1'b1, 16'h00F0, 1'b1, 7};

    for (int t = 0; t < 10; t++) begin
      grant_ready = 1'b0; req = 16'h0000;
      do_reset();
      mode = tbl[t].mode; enable = tbl[t].en; req = tbl[t].req;
      tick();
      chk_grant($sformatf("table%0d", t), tbl[t].exp_valid, tbl[t].exp_idx);
    end

    // Fixed priority drain, req cleared as each grant is taken.
    req = 16'h0000; grant_ready = 1'b0;
    do_reset();
    mode = 1'b0; enable = 1'b1; grant_ready = 1'b1; req = 16'h0112;
    tick(); chk_grant("fixed_seq0", 1'b1, 8);
    req = 16'h0012;
    tick(); chk_grant("fixed_seq1", 1'b1, 4);
    req = 16'h0002;
    tick(); chk_grant("fixed_seq2", 1'b1, 1);
    req = 16'h0000;
    tick(); chk_grant("fixed_seq_end", 1'b0, 0);

    // Round-robin alternation with wrap.
    grant_ready = 1'b0;
    do_reset();
    mode = 1'b1; enable = 1'b1; grant_ready = 1'b1; req = 16'h8001;
    tick(); chk_grant("rr_alt0", 1'b1, 0);
    tick(); chk_grant("rr_alt1", 1'b1, 15);
    tick(); chk_grant("rr_alt2", 1'b1, 0);
    tick(); chk_grant("rr_alt3", 1'b1, 15);

    // Stall holds the grant regardless of req/enable/mode.
    grant_ready = 1'b0; req = 16'h0000;
    do_reset();
    mode = 1'b0; enable = 1'b1; req = 16'h0020;
    tick(); chk_grant("stall_load", 1'b1, 5);
    req = 16'h0000; enable = 1'b0; mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); chk_grant($sformatf("stall_hold%0d", c), 1'b1, 5);
    end
    grant_ready = 1'b1;
    tick(); chk_grant("stall_release", 1'b0, 0);

    // Asynchronous reset in the middle of HOLD.
    grant_ready = 1'b0; req = 16'h0000;
    do_reset();
    mode = 1'b0; enable = 1'b1; req = 16'h0040;
    tick(); chk_grant("arst_hold", 1'b1, 6);
    #2 rst = 1'b1;
    #1 chk_grant("arst_mid", 1'b0, 0);
    #1 rst = 1'b0; req = 16'h0004;
    tick(); chk_grant("arst_after", 1'b1, 2);

    // Enable gating, then round-robin starts at channel 0.
    grant_ready = 1'b0; req = 16'h0000;
    do_reset();
    mode = 1'b1; enable = 1'b0; req = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_grant($sformatf("en_low%0d", c), 1'b0, 0);
    end
    enable = 1'b1;
    tick(); chk_grant("en_rise", 1'b1, 0);

    // Randomized run against the reference model.
    grant_ready = 1'b0; req = 16'h0000; enable = 1'b1; mode = 1'b1;
    do_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0; max_wait = 0;
    for (int c = 0; c < N; c++) wait_cnt[c] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(7) == 0) req = 16'($urandom() & $urandom());
      grant_ready = 1'($urandom_range(1));
      if ($urandom_range(63) == 0) mode = ~mode;
      enable = ($urandom_range(15) != 0);
      @(posedge clk);
      hs = (m_valid != 0) && grant_ready;
      for (int c = 0; c < N; c++) begin
        if (!req[c] || !mode) wait_cnt[c] = 0;
        else if (hs) wait_cnt[c]++;
        if (wait_cnt[c] > max_wait) max_wait = wait_cnt[c];
      end
      if (m_valid == 0 || hs) begin
        if (hs) m_ptr = (m_idx + 1) % N;
        if (enable && req != 16'h0000) begin
          w = mode ? rr_pick(req, m_ptr) : fixed_pick(req);
          m_valid = 1; m_idx = w;
          wait_cnt[w] = 0;
        end else begin
          m_valid = 0; m_idx = 0;
        end
      end
      #1;
      chk_grant("random", 1'(m_valid), m_idx);
    end
    chk("rr_starvation_bound", 64'(max_wait <= N), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 16, meaning number of request channels; legal range 2..64.
REQ-002 Parameter W, default $clog2(N), meaning width of the grant index; not overridden by instantiators.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  arbitration enable; low blocks new grants only.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 req  input  N  per-channel request vector, level-sensitive.
REQ-008 grant_valid  output  1  a grant is presented.
REQ-009 grant_idx  output  W  index of the granted channel, valid when grant_valid=1.
REQ-010 grant_onehot  output  N  one-hot form of grant_idx; all zero when grant_valid=0.
REQ-011 grant_ready  input  1  consumer accepts the grant; handshake = grant_valid & grant_ready.

Function
REQ-012 FSM has two states: IDLE (no grant held) and HOLD (grant presented).
REQ-013 Arbitration happens only in IDLE, or in HOLD on a handshake cycle; "eligible" = enable=1 and req!=0.
REQ-014 Fixed mode: winner = highest set index of req.
REQ-015 Round-robin mode: winner = lowest set index >= ptr; if none, lowest set index overall (wrap-around).
REQ-016 ptr is a W-bit register; on every handshake ptr <= (grant_idx+1) mod N, with N-1 wrapping to 0; ptr also updates in fixed mode.
REQ-017 IDLE, eligible: next cycle grant_valid=1, grant_idx/grant_onehot = winner, state HOLD (1-cycle latency req->grant).
REQ-018 IDLE, not eligible: outputs stay zero, state IDLE.
REQ-019 HOLD, no handshake: grant_valid, grant_idx, grant_onehot held stable, even if req drops, enable falls or mode changes.
REQ-020 HOLD, handshake, eligible: new winner loaded next cycle, state stays HOLD (back-to-back grants, no bubble).
REQ-021 HOLD, handshake, not eligible: next cycle grant_valid=0, outputs zero, state IDLE.
REQ-022 Arbitration on a handshake cycle uses the current req and the pre-update ptr masked past the accepted index (equivalently, the updated ptr); the same channel may win again only if it is the sole requester or wins under fixed priority.
REQ-023 mode and enable are sampled only on arbitration cycles.
REQ-024 grant_ready while grant_valid=0 is ignored.
REQ-025 grant_onehot == (1 << grant_idx) whenever grant_valid=1.

Reset
REQ-026 rst=1 forces immediately, without a clock edge: state IDLE, ptr 0, grant_valid 0, grant_idx 0, grant_onehot 0.
REQ-027 Reset asserted mid-HOLD discards the pending grant; no handshake is reported.
REQ-028 First grant after rst deassertion follows REQ-017, with ptr=0.

Structure
REQ-029 Shared package holds the state encoding constants (IDLE, HOLD) and mode constants (MODE_FIXED=0, MODE_RR=1).
REQ-030 One sub-module, prio_pick (parameter N): combinational, inputs a vector, outputs lowest set index and a found flag; instantiated for the masked and unmasked round-robin searches, with fixed mode fed the bit-reversed vector.
REQ-031 All outputs driven directly from registers; no combinational path from req, enable or mode to outputs.

Verification (N=16)
REQ-032 mode=0, enable=1, req=0x0112, grant_ready=1 -> grants 8, 4, 1 on consecutive cycles, while req is cleared per grant.
REQ-033 mode=1, req=0x8001 held, grant_ready=1 -> grants alternate 0, 15, 0, 15; ptr wraps from 0 to 1 to 0.
REQ-034 grant_idx=5 held, grant_ready=0 for 4 cycles, req dropped to 0x0000 and enable=0 -> grant_valid=1, idx 5 stable; on ready, grant_valid=0 next cycle.
REQ-035 rst pulsed asynchronously between clock edges while in HOLD -> all outputs 0 before the next edge; after release, req=0x0004 -> grant_idx=2 one cycle later.
REQ-036 enable=0, req=0xFFFF -> grant_valid stays 0; enable raised -> mode=1 grants 0 first (ptr=0).
REQ-037 Random req, ready and mode for 10k cycles -> onehot/idx consistency, output stability while stalled, and no starvation under mode=1 (each persistent requester granted within N handshakes).
